spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Synchronous SPI initiator that drives the command/data frames consumed by the team's SPI slave + single-port RAM subsystem.
- Accepts 10-bit command words from a host-side valid/ready interface and serialises them MSB-first on MOSI under SS_n.
- For read-data commands (word[9:8]=2'b11), captures the 8-bit reply on MISO and returns it to the host.
- Shares clk with the slave; there is no separate SCLK.

Parameters:
- TURNAROUND, 2: cycles SS_n stays low between the last MOSI bit and the first MISO sample of a read-data frame (1..15).
- IDLE_GAP, 1: cycles SS_n is held high after a frame before cmd_ready reasserts (1..15).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  host presents cmd_data.
- cmd_ready  output  1  block can accept a command.
- cmd_data  input  10  [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- rd_valid  output  1  one-cycle pulse; rd_data is valid.
- rd_data  output  8  byte captured from MISO.
- busy  output  1  a frame is in progress (state != IDLE).
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to the slave.
- MISO  input  1  serial data from the slave.
- cmd_err  output  1  sticky sequencing error; driven only when SPI_SEQ_CHECK_EN is defined, otherwise tied 0.

Behaviour:
- Reset (async, rst=1): state=IDLE, SS_n=1, MOSI=0, cmd_ready=1, rd_valid=0, rd_data=0, busy=0, cmd_err=0, all counters cleared. A frame interrupted by reset is abandoned; SS_n rises in the same cycle rst asserts. No rd_valid is produced for the abandoned frame.
- Handshake:
  - cmd_ready=1 only in IDLE with the gap counter expired.
  - A command is accepted on the clk edge where cmd_valid && cmd_ready; call that accept cycle A. cmd_data is registered at that edge.
  - cmd_ready drops in A+1.
  - cmd_data is a don't-care when no handshake occurs.
- States: IDLE -> SEL -> CMD -> SHIFT -> (opcode 11 ? TURN -> RX : HOLD) -> END -> IDLE.
- Pin timing, in cycles after A:
  - A+1 (SEL): SS_n=0, MOSI=0.
  - A+2 (CMD): MOSI=word[9]. This is the direction bit the slave checks.
  - A+3..A+12 (SHIFT): MOSI=word[9], word[8], ... word[0]. The 4-bit bit counter counts down from 9 to 0.
  - Opcodes 00, 01, 10: A+13 (HOLD) keeps SS_n=0, MOSI=0 so the slave can latch; A+14 (END) sets SS_n=1.
  - Opcode 11:
    - TURN lasts TURNAROUND cycles with SS_n=0, MOSI=0.
    - RX lasts 8 cycles; MISO is sampled at each posedge and shifted into rd_data MSB-first.
    - END sets SS_n=1, rd_valid=1 for exactly one cycle, and rd_data updates at the same time.
- Gap: after END, SS_n stays high for IDLE_GAP cycles, then cmd_ready=1. Back-to-back commands are therefore separated by at least IDLE_GAP+1 cycles with SS_n high.
- rd_data holds its last value until the next rd-data frame completes.
- busy=1 from A+1 through END inclusive.
- cmd_valid asserted while busy has no effect; the host must hold it (standard valid/ready).
- MISO is ignored outside RX.
- MOSI is 0 whenever SS_n=1.

Optional Feature:
- SPI_SEQ_CHECK_EN.
- When defined: the block tracks a "read address pending" bit.
  - Set on completion of an opcode-10 frame.
  - Cleared on completion of an opcode-11 frame.
  - Accepting opcode 11 while the bit is clear sets cmd_err=1 (sticky until rst). The frame is still sent normally.
  - Accepting opcode 10 while the bit is set also sets cmd_err.
- When undefined: no tracking logic; cmd_err is tied to 0.

Test Plan:
1. Reset then idle -> SS_n=1, MOSI=0, cmd_ready=1, rd_valid=0, busy=0. Assert rst for 1 cycle mid-SHIFT -> SS_n=1 immediately, state IDLE, no rd_valid.
2. Write address, cmd_data=10'b00_1010_0101 -> SS_n low A+1..A+13; MOSI A+2=0, then A+3..A+12 = 0,0,1,0,1,0,0,1,0,1; SS_n high A+14; cmd_ready at A+15 (IDLE_GAP=1).
3. Read data, cmd_data=10'b11_0000_0000, TURNAROUND=2, MISO driven 8'hC3 MSB-first over the 8 RX cycles -> rd_valid single pulse at A+23 with rd_data=8'hC3; SS_n high the same cycle.
4. Back-to-back: cmd_valid held high with two commands (01 then 10) -> second accept occurs exactly IDLE_GAP+1 cycles after the first END; SS_n is high for IDLE_GAP+1 cycles between frames; both frames bit-exact.
5. cmd_valid pulsed while busy, then dropped -> nothing is accepted; the next frame starts only after a valid handshake in IDLE.
6. With SPI_SEQ_CHECK_EN: opcode 11 with no prior opcode 10 -> cmd_err=1 and stays 1. Sequence 10 then 11 after reset -> cmd_err stays 0. Without the macro -> cmd_err=0 throughout.

Source files
------------

// File: rtl/spi_master.sv
// SPI initiator: serialises 10-bit command words on MOSI under SS_n and captures 8-bit read replies.
// Optional SPI_SEQ_CHECK_EN adds a sticky rd-addr/rd-data sequencing error flag on cmd_err.
module spi_master #(
    parameter int TURNAROUND = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic       cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_CMD, S_SHIFT, S_TURN, S_RX, S_HOLD, S_END
    } state_t;

    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;
    localparam logic [3:0] TURN_LOAD  = 4'(TURNAROUND - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(IDLE_GAP - 1);

    state_t     state_q, state_d;
    logic [9:0] word_q;
    logic [3:0] bit_cnt;
    logic [3:0] turn_cnt;
    logic [2:0] rx_cnt;
    logic [6:0] rx_shift;
    logic [3:0] gap_cnt;
    logic       accept;
    logic       is_read;

    assign accept  = cmd_valid && cmd_ready;
    assign is_read = (word_q[9:8] == OP_RD_DATA);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: the default assignment at the top keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SEL;
            S_SEL:   state_d = S_CMD;
            S_CMD:   state_d = S_SHIFT;
            S_SHIFT: if (bit_cnt == 4'd0) state_d = is_read ? S_TURN : S_HOLD;
            S_TURN:  if (turn_cnt == 4'd0) state_d = S_RX;
            S_RX:    if (rx_cnt == 3'd7) state_d = S_END;
            S_HOLD:  state_d = S_END;
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pins decode straight from the state register so SS_n rises as soon as rst asserts.
    always_comb begin
        SS_n      = 1'b1;
        MOSI      = 1'b0;
        busy      = 1'b1;
        cmd_ready = 1'b0;
        rd_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = (gap_cnt == 4'd0);
            end
            S_SEL, S_TURN, S_RX, S_HOLD: SS_n = 1'b0;
            S_CMD: begin
                SS_n = 1'b0;
                MOSI = word_q[9];
            end
            S_SHIFT: begin
                SS_n = 1'b0;
                MOSI = word_q[bit_cnt];
            end
            S_END:   rd_valid = is_read;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= '0;
            bit_cnt  <= '0;
            turn_cnt <= '0;
            rx_cnt   <= '0;
            rx_shift <= '0;
            gap_cnt  <= '0;
            rd_data  <= '0;
        end else begin
            if (accept) word_q <= cmd_data;
            case (state_q)
                S_IDLE: if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
                S_SEL:  rx_cnt <= '0;
                S_CMD:  bit_cnt <= 4'd9;
                S_SHIFT: begin
                    bit_cnt <= bit_cnt - 4'd1;
                    if (bit_cnt == 4'd0) turn_cnt <= TURN_LOAD;
                end
                S_TURN: turn_cnt <= turn_cnt - 4'd1;
                S_RX: begin
                    rx_shift <= {rx_shift[5:0], MISO};
                    rx_cnt   <= rx_cnt + 3'd1;
                    // The last sample goes straight into rd_data so it appears together with rd_valid.
                    if (rx_cnt == 3'd7) rd_data <= {rx_shift, MISO};
                end
                S_END:  gap_cnt <= GAP_LOAD;
                default: ;
            endcase
        end
    end

`ifdef SPI_SEQ_CHECK_EN
    logic rd_pend;
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept && ((cmd_data[9:8] == OP_RD_DATA && !rd_pend) ||
                           (cmd_data[9:8] == OP_RD_ADDR &&  rd_pend)))
                err_q <= 1'b1;
            if (state_q == S_END) begin
                if (word_q[9:8] == OP_RD_ADDR)      rd_pend <= 1'b1;
                else if (word_q[9:8] == OP_RD_DATA) rd_pend <= 1'b0;
            end
        end
    end

    assign cmd_err = err_q;
`else
    assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Randomised self-checking bench for spi_master against a cycle-timeline model of each frame.
module tb_spi_master;

    localparam int TA  = 2;
    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic       cmd_err;

    spi_master #(.TURNAROUND(TA), .IDLE_GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rd = '0;
    bit         pend   = 1'b0;
    bit         err    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ss_n"}, 32'(SS_n), 1);
        check({tag, " mosi"}, 32'(MOSI), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " ready"}, 32'(cmd_ready), 1);
        check({tag, " rd_valid"}, 32'(rd_valid), 0);
        check({tag, " rd_data"}, 32'(rd_data), 32'(exp_rd));
        check({tag, " cmd_err"}, 32'(cmd_err), 32'(err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        MISO = 1'b0;
        exp_rd = '0;
        pend = 1'b0;
        err = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle("idle");
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    // Drives one frame from the accept edge to the first cycle cmd_ready is back,
    // checking every pin against the cycle timeline the block is meant to follow.
    task automatic frame(input logic [9:0] word, input logic [7:0] rx_byte,
                         input bit hold, input bit poke);
        bit rd;
        bit ok;
        int end_k;
        int last;
        logic e_ss, e_mosi, e_busy, e_rv, e_rdy;
        rd    = (word[9:8] == 2'b11);
        end_k = rd ? 21 + TA : 14;
        last  = end_k + GAP;
        cmd_valid = 1'b1;
        cmd_data  = word;
        wait_ready(ok);
        if (!ok) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
`ifdef SPI_SEQ_CHECK_EN
        if ((word[9:8] == 2'b11 && !pend) || (word[9:8] == 2'b10 && pend)) err = 1'b1;
`endif
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (!hold && k == 1) cmd_valid = 1'b0;
            if (poke) begin
                cmd_valid = (k >= 4 && k <= 7);
                cmd_data  = 10'($urandom);
            end
            e_ss   = !(k < end_k);
            e_busy = (k <= end_k);
            e_rv   = rd && (k == end_k);
            e_rdy  = (k == last);
            e_mosi = 1'b0;
            if (k == 2) e_mosi = word[9];
            else if (k >= 3 && k <= 12) e_mosi = word[12 - k];
            if (k == end_k) begin
                if (rd) exp_rd = rx_byte;
            end
            check($sformatf("ss_n k=%0d", k), 32'(SS_n), 32'(e_ss));
            check($sformatf("mosi k=%0d", k), 32'(MOSI), 32'(e_mosi));
            check($sformatf("busy k=%0d", k), 32'(busy), 32'(e_busy));
            check($sformatf("rd_valid k=%0d", k), 32'(rd_valid), 32'(e_rv));
            check($sformatf("ready k=%0d", k), 32'(cmd_ready), 32'(e_rdy));
            check($sformatf("rd_data k=%0d", k), 32'(rd_data), 32'(exp_rd));
            check($sformatf("cmd_err k=%0d", k), 32'(cmd_err), 32'(err));
            if (k == end_k) begin
                if (word[9:8] == 2'b10) pend = 1'b1;
                else if (word[9:8] == 2'b11) pend = 1'b0;
            end
            if (rd && k >= 13 + TA && k <= 20 + TA) MISO = rx_byte[7 - (k - 13 - TA)];
            else MISO = 1'($urandom);
        end
    endtask

    task automatic reset_mid_frame();
        bit ok;
        cmd_valid = 1'b1;
        cmd_data  = 10'b11_0101_1010;
        wait_ready(ok);
        if (!ok) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid ss_n before rst", 32'(SS_n), 0);
        rst = 1'b1;
        #1;
        check("mid ss_n async", 32'(SS_n), 1);
        check("mid busy async", 32'(busy), 0);
        check("mid mosi async", 32'(MOSI), 0);
        exp_rd = '0;
        pend = 1'b0;
        err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            MISO = 1'($urandom);
            @(negedge clk);
            check_idle("after_mid_rst");
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = '0;
        MISO = 1'b0;
        #1;
        check_idle("async_reset");
        do_reset();

        frame(10'b00_1010_0101, 8'h00, 1'b0, 1'b0);
        frame(10'b11_0000_0000, 8'hC3, 1'b0, 1'b0);
        idle_cycles(3);

        frame({2'b01, 8'($urandom)}, 8'h00, 1'b1, 1'b0);
        frame({2'b10, 8'($urandom)}, 8'h00, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        idle_cycles(2);

        frame({2'b00, 8'($urandom)}, 8'h00, 1'b0, 1'b1);
        idle_cycles(4);
        frame({2'b11, 8'($urandom)}, 8'($urandom), 1'b0, 1'b1);
        idle_cycles(4);

        reset_mid_frame();

        do_reset();
        frame(10'b10_0000_0111, 8'h00, 1'b0, 1'b0);
        frame(10'b11_0000_0000, 8'h5A, 1'b0, 1'b0);
        check("seq ok cmd_err", 32'(cmd_err), 0);

        do_reset();
        frame(10'b11_0000_0000, 8'hA5, 1'b0, 1'b0);
        frame(10'b00_0000_0001, 8'h00, 1'b0, 1'b0);
`ifdef SPI_SEQ_CHECK_EN
        check("seq bad cmd_err", 32'(cmd_err), 1);
`else
        check("seq bad cmd_err", 32'(cmd_err), 0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [9:0] w;
            bit h, p;
            w = 10'($urandom);
            h = ($urandom_range(0, 3) == 0);
            p = !h && ($urandom_range(0, 3) == 0);
            frame(w, 8'($urandom), h, p);
            if (!h) begin
                cmd_valid = 1'b0;
                idle_cycles($urandom_range(0, 3));
            end
        end
        cmd_valid = 1'b0;
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
